// File: rtl/hazard_pkg.sv
// Shared types and defaults for the hazard scheduler (state encoding, counter widths).
package hazard_pkg;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  localparam int MD_CNT_W        = 5;
  localparam int WAIT_CNT_W      = 16;
  localparam int PERF_CNT_W      = 32;
  localparam int MD_LATENCY_DEF  = 5;
  localparam int MEM_TIMEOUT_DEF = 255;

  // Wrapping event counter step.
  function automatic logic [PERF_CNT_W-1:0] perf_step(input logic [PERF_CNT_W-1:0] cnt,
                                                      input logic inc);
    return cnt + {{(PERF_CNT_W-1){1'b0}}, inc};
  endfunction

  // Saturating wait-counter step.
  function automatic logic [WAIT_CNT_W-1:0] wait_step(input logic [WAIT_CNT_W-1:0] cnt,
                                                      input logic [WAIT_CNT_W-1:0] limit);
    return (cnt >= limit) ? limit : cnt + 16'd1;
  endfunction

endpackage

// File: rtl/hazard_sched_md_busy_cnt.sv
// Mult/div occupancy down-counter; keeps counting while the pipeline is frozen,
// but a start is only accepted when hold_n is high.
module md_busy_cnt
  import hazard_pkg::*;
#(
  parameter int LATENCY = MD_LATENCY_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic hold_n,
  output logic busy
);

  localparam logic [MD_CNT_W-1:0] LOAD_VAL = MD_CNT_W'(LATENCY);

  logic [MD_CNT_W-1:0] cnt_q;
  logic [MD_CNT_W-1:0] cnt_d;

  // Next count: reload on accepted start, otherwise drain towards zero.
  always_comb begin
    cnt_d = cnt_q;
    if (start && hold_n) begin
      cnt_d = LOAD_VAL;
    end else if (cnt_q != {MD_CNT_W{1'b0}}) begin
      cnt_d = cnt_q - {{(MD_CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= {MD_CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy = (cnt_q != {MD_CNT_W{1'b0}});

endmodule

// File: rtl/hazard_sched.sv
// Prioritised stall/flush scheduler for the 5-stage core. Optional perf counters
// are built only when HAZARD_PERF_CNT_EN is defined; otherwise the ports read zero.
module hazard_sched
  import hazard_pkg::*;
#(
  parameter int MD_LATENCY  = MD_LATENCY_DEF,
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_use,
  input  logic        D_branch_taken,
  input  logic        D_md_use,
  input  logic        E_md_start,
  input  logic        M_mem_req,
  input  logic        M_mem_ready,
  output logic        PC_en,
  output logic        D_en,
  output logic        E_en,
  output logic        M_en,
  output logic        D_clr,
  output logic        E_clr,
  output logic        W_clr,
  output logic        md_busy,
  output logic        mem_err,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt,
  output logic [31:0] memwait_cnt
);

  localparam logic [WAIT_CNT_W-1:0] TIMEOUT_VAL = WAIT_CNT_W'(MEM_TIMEOUT);

  logic freeze;
  logic md_stall;
  logic stall;
  logic flush;

  state_e                state_q;
  state_e                state_d;
  logic [WAIT_CNT_W-1:0] wait_cnt_q;
  logic [WAIT_CNT_W-1:0] wait_cnt_d;
  logic                  mem_err_q;
  logic                  mem_err_d;

  md_busy_cnt #(
    .LATENCY (MD_LATENCY)
  ) u_md_busy_cnt (
    .clk    (clk),
    .rst    (rst),
    .start  (E_md_start),
    .hold_n (~freeze),
    .busy   (md_busy)
  );

  // A freeze masks every lower-priority hazard; a flush needs ID to be moving.
  always_comb begin
    freeze   = M_mem_req & ~M_mem_ready;
    md_stall = D_md_use & md_busy;
    stall    = ~freeze & (md_stall | load_use);
    flush    = ~freeze & ~stall & D_branch_taken;
  end

  // Per-stage enables and bubbles; reset clears every pipeline register.
  always_comb begin
    PC_en = 1'b1;
    D_en  = 1'b1;
    E_en  = 1'b1;
    M_en  = 1'b1;
    D_clr = 1'b0;
    E_clr = 1'b0;
    W_clr = 1'b0;
    if (rst) begin
      D_clr = 1'b1;
      E_clr = 1'b1;
      W_clr = 1'b1;
    end else if (freeze) begin
      PC_en = 1'b0;
      D_en  = 1'b0;
      E_en  = 1'b0;
      M_en  = 1'b0;
      W_clr = 1'b1;
    end else if (stall) begin
      PC_en = 1'b0;
      D_en  = 1'b0;
      E_clr = 1'b1;
    end else if (flush) begin
      D_clr = 1'b1;
    end else begin
      D_clr = 1'b0;
    end
  end

  // Memory-wait FSM with saturating wait counter and sticky timeout flag.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      RUN: begin
        if (freeze) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = {{(WAIT_CNT_W-1){1'b0}}, 1'b1};
        end else begin
          state_d    = RUN;
          wait_cnt_d = {WAIT_CNT_W{1'b0}};
        end
      end
      MEM_WAIT: begin
        if (freeze) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = wait_step(wait_cnt_q, TIMEOUT_VAL);
        end else begin
          state_d    = RUN;
          wait_cnt_d = {WAIT_CNT_W{1'b0}};
        end
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = {WAIT_CNT_W{1'b0}};
      end
    endcase
    mem_err_d = mem_err_q | (freeze & (wait_cnt_d == TIMEOUT_VAL));
  end

  // FSM state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      wait_cnt_q <= {WAIT_CNT_W{1'b0}};
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
    end
  end

  assign mem_err = mem_err_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [PERF_CNT_W-1:0] stall_cnt_q;
  logic [PERF_CNT_W-1:0] stall_cnt_d;
  logic [PERF_CNT_W-1:0] flush_cnt_q;
  logic [PERF_CNT_W-1:0] flush_cnt_d;
  logic [PERF_CNT_W-1:0] memwait_cnt_q;
  logic [PERF_CNT_W-1:0] memwait_cnt_d;

  // Event counts; stall and flush already exclude freeze cycles.
  always_comb begin
    stall_cnt_d   = perf_step(stall_cnt_q, stall);
    flush_cnt_d   = perf_step(flush_cnt_q, flush);
    memwait_cnt_d = perf_step(memwait_cnt_q, freeze);
  end

  // Perf counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q   <= 32'd0;
      flush_cnt_q   <= 32'd0;
      memwait_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q   <= stall_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
      memwait_cnt_q <= memwait_cnt_d;
    end
  end

  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;
  assign memwait_cnt = memwait_cnt_q;
`else
  assign stall_cnt   = 32'd0;
  assign flush_cnt   = 32'd0;
  assign memwait_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_sched.sv
// Self-checking bench for hazard_sched: directed table of cycles plus random
// stimulus, both compared against a cycle-level reference model.
module tb_hazard_sched;

  localparam int MD_LAT = 5;
  localparam int TO     = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, load_use, D_branch_taken, D_md_use, E_md_start, M_mem_req, M_mem_ready;
  logic PC_en, D_en, E_en, M_en, D_clr, E_clr, W_clr, md_busy, mem_err;
  logic [31:0] stall_cnt, flush_cnt, memwait_cnt;

  hazard_sched #(.MD_LATENCY(MD_LAT), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .load_use(load_use), .D_branch_taken(D_branch_taken),
    .D_md_use(D_md_use), .E_md_start(E_md_start), .M_mem_req(M_mem_req),
    .M_mem_ready(M_mem_ready), .PC_en(PC_en), .D_en(D_en), .E_en(E_en), .M_en(M_en),
    .D_clr(D_clr), .E_clr(E_clr), .W_clr(W_clr), .md_busy(md_busy), .mem_err(mem_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .memwait_cnt(memwait_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: cycles of mult/div left, freeze run length, sticky error, counts.
  int          m_md  = 0;
  int          m_run = 0;
  bit          m_err = 1'b0;
  logic [31:0] m_sc  = 32'd0;
  logic [31:0] m_fc  = 32'd0;
  logic [31:0] m_mc  = 32'd0;

  // input bits: {rst, load_use, branch, md_use, md_start, mem_req, mem_ready}
  localparam logic [6:0] I_IDLE = 7'b0000000, I_RST = 7'b1000000, I_LU = 7'b0100000,
                         I_LUBR = 7'b0110000, I_BR = 7'b0010000, I_RQRD = 7'b0000011,
                         I_FRZLU = 7'b0100010, I_FRZ = 7'b0000010, I_MS = 7'b0000100,
                         I_MU = 7'b0001000, I_MSFRZ = 7'b0000110, I_FRZRST = 7'b1000010;
  // control bits: {PC_en, D_en, E_en, M_en, D_clr, E_clr, W_clr}
  localparam logic [6:0] C_DEF = 7'b1111000, C_STL = 7'b0011010, C_FL = 7'b1111100,
                         C_FRZ = 7'b0000001, C_RST = 7'b1111111;

  typedef struct {
    logic [6:0] in;
    logic [6:0] ctl;
    logic       busy;
    logic       err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [6:0] in, input logic [6:0] ctl,
                              input logic busy, input logic err);
    vec_t v;
    v.in = in; v.ctl = ctl; v.busy = busy; v.err = err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [6:0] in);
    {rst, load_use, D_branch_taken, D_md_use, E_md_start, M_mem_req, M_mem_ready} = in;
  endtask

  function automatic logic [6:0] model_ctl();
    bit frz, stl;
    frz = M_mem_req && !M_mem_ready;
    stl = load_use || (D_md_use && m_md > 0);
    if (rst) return C_RST;
    if (frz) return C_FRZ;
    if (stl) return C_STL;
    if (D_branch_taken) return C_FL;
    return C_DEF;
  endfunction

  task automatic check_model(input string tag);
    chk({tag, " ctl"}, {25'd0, PC_en, D_en, E_en, M_en, D_clr, E_clr, W_clr},
        {25'd0, model_ctl()});
    chk({tag, " md_busy"}, {31'd0, md_busy}, {31'd0, (m_md > 0)});
    chk({tag, " mem_err"}, {31'd0, mem_err}, {31'd0, m_err});
    chk({tag, " stall_cnt"}, stall_cnt, m_sc);
    chk({tag, " flush_cnt"}, flush_cnt, m_fc);
    chk({tag, " memwait_cnt"}, memwait_cnt, m_mc);
  endtask

  // Advance one clock and apply the cycle's effect to the model.
  task automatic tick();
    bit frz, stl, fl;
    @(posedge clk);
    if (rst) begin
      m_md = 0; m_run = 0; m_err = 1'b0;
      m_sc = 32'd0; m_fc = 32'd0; m_mc = 32'd0;
    end else begin
      frz = M_mem_req && !M_mem_ready;
      stl = !frz && (load_use || (D_md_use && m_md > 0));
      fl  = !frz && !stl && D_branch_taken;
      if (E_md_start && !frz) m_md = MD_LAT;
      else if (m_md > 0) m_md--;
      if (frz) begin
        if (m_run < TO) m_run++;
        if (m_run >= TO) m_err = 1'b1;
      end else begin
        m_run = 0;
      end
`ifdef HAZARD_PERF_CNT_EN
      if (stl) m_sc++;
      if (fl)  m_fc++;
      if (frz) m_mc++;
`endif
    end
    #1;
  endtask

  initial begin
    tbl.push_back(mk(I_RST,  C_RST, 1'b0, 1'b0));
    tbl.push_back(mk(I_IDLE, C_DEF, 1'b0, 1'b0));
    tbl.push_back(mk(I_LU,   C_STL, 1'b0, 1'b0));
    tbl.push_back(mk(I_IDLE, C_DEF, 1'b0, 1'b0));
    tbl.push_back(mk(I_LUBR, C_STL, 1'b0, 1'b0));
    tbl.push_back(mk(I_BR,   C_FL,  1'b0, 1'b0));
    tbl.push_back(mk(I_RQRD, C_DEF, 1'b0, 1'b0));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(I_FRZLU, C_FRZ, 1'b0, 1'b0));
    tbl.push_back(mk(I_RQRD, C_DEF, 1'b0, 1'b0));
    tbl.push_back(mk(I_MS,   C_DEF, 1'b0, 1'b0));
    for (int i = 0; i < 5; i++) tbl.push_back(mk(I_MU, C_STL, 1'b1, 1'b0));
    tbl.push_back(mk(I_MU,    C_DEF, 1'b0, 1'b0));
    tbl.push_back(mk(I_MSFRZ, C_FRZ, 1'b0, 1'b0));
    tbl.push_back(mk(I_FRZ,   C_FRZ, 1'b0, 1'b0));
    tbl.push_back(mk(I_MS,    C_DEF, 1'b0, 1'b0));
    tbl.push_back(mk(I_FRZ,   C_FRZ, 1'b1, 1'b0));
    tbl.push_back(mk(I_MSFRZ, C_FRZ, 1'b1, 1'b0));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(I_IDLE, C_DEF, 1'b1, 1'b0));
    tbl.push_back(mk(I_IDLE, C_DEF, 1'b0, 1'b0));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(I_FRZ, C_FRZ, 1'b0, 1'b0));
    for (int i = 0; i < 2; i++) tbl.push_back(mk(I_FRZ, C_FRZ, 1'b0, 1'b1));
    tbl.push_back(mk(I_IDLE,   C_DEF, 1'b0, 1'b1));
    tbl.push_back(mk(I_RST,    C_RST, 1'b0, 1'b1));
    tbl.push_back(mk(I_IDLE,   C_DEF, 1'b0, 1'b0));
    tbl.push_back(mk(I_MS,     C_DEF, 1'b0, 1'b0));
    tbl.push_back(mk(I_FRZ,    C_FRZ, 1'b1, 1'b0));
    tbl.push_back(mk(I_FRZ,    C_FRZ, 1'b1, 1'b0));
    tbl.push_back(mk(I_FRZRST, C_RST, 1'b1, 1'b0));
    tbl.push_back(mk(I_IDLE,   C_DEF, 1'b0, 1'b0));

    drive(I_RST);
    tick();

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].in);
      @(negedge clk);
      chk($sformatf("row%0d ctl", i),
          {25'd0, PC_en, D_en, E_en, M_en, D_clr, E_clr, W_clr}, {25'd0, tbl[i].ctl});
      chk($sformatf("row%0d md_busy", i), {31'd0, md_busy}, {31'd0, tbl[i].busy});
      chk($sformatf("row%0d mem_err", i), {31'd0, mem_err}, {31'd0, tbl[i].err});
      check_model($sformatf("row%0d", i));
      tick();
    end

    for (int c = 0; c < 800; c++) begin
      logic [6:0] in;
      in[6] = ($urandom_range(59) == 0);
      in[5] = ($urandom_range(4) == 0);
      in[4] = ($urandom_range(3) == 0);
      in[3] = ($urandom_range(2) == 0);
      in[2] = ($urandom_range(5) == 0);
      in[1] = ($urandom_range(1) == 0);
      in[0] = ($urandom_range(2) == 0);
      drive(in);
      @(negedge clk);
      check_model($sformatf("rnd%0d", c));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_sched.md
# hazard_sched

Pipeline stall/flush scheduler for the 5-stage MIPS core. Combines the load-use flag from the load-use detector with branch-taken, data-memory wait and multiply/divide-busy conditions. Produces one prioritised set of per-stage enable/clear controls each cycle. Tracks memory-wait and mult/div occupancy with internal counters and an FSM.

## Interface
Parameters:
- MD_LATENCY, 5, cycles the mult/div unit stays busy after a start (1..31)
- MEM_TIMEOUT, 255, consecutive memory-wait cycles before `mem_err` is raised (1..65535)

Ports:
- clk  in  1  core clock
- rst  in  1  reset; synchronous, active-high
- load_use  in  1  load-use hazard flag (EX load feeds ID)
- D_branch_taken  in  1  ID-stage branch/jump resolved taken
- D_md_use  in  1  ID instruction reads HI/LO or starts mult/div
- E_md_start  in  1  EX instruction starts mult/div
- M_mem_req  in  1  MEM stage is accessing data memory
- M_mem_ready  in  1  data memory completes this cycle
- PC_en, D_en, E_en, M_en  out  1 each  pipeline-register write enables
- D_clr, E_clr, W_clr  out  1 each  insert bubble into IF/ID, ID/EX, MEM/WB
- md_busy  out  1  mult/div counter non-zero
- mem_err  out  1  sticky memory timeout flag
- stall_cnt, flush_cnt, memwait_cnt  out  32 each  performance counters

## Operation
Conditions, highest priority first (combinational, same cycle):
- **freeze** = `M_mem_req && !M_mem_ready`:
  - PC_en=D_en=E_en=M_en=0, W_clr=1.
  - All other stalls and flushes are suppressed.
- **md_stall** = `D_md_use && md_busy`:
  - PC_en=D_en=0, E_clr=1.
- **load_use**: same controls as md_stall.
- **flush** = `D_branch_taken`, only when no stall is active:
  - D_clr=1.
  - ID is stalled otherwise, so the branch is unresolved and no flush happens.
- Default: all enables 1, all clears 0.

FSM, 2 states:
- RUN:
  - freeze → MEM_WAIT, wait_cnt=1.
- MEM_WAIT:
  - freeze → stay, wait_cnt++ (saturating).
  - no freeze → RUN, wait_cnt=0.
  - When wait_cnt reaches MEM_TIMEOUT, mem_err is set. It stays set until rst. The pipeline stays frozen.

Mult/div counter md_cnt, width 5:
- `E_md_start && !freeze` loads MD_LATENCY.
- Otherwise it decrements when non-zero.
- It counts through freezes, because the unit runs independently.
- md_busy = (md_cnt != 0).

Reset (rst high at edge):
- state=RUN, wait_cnt=0, md_cnt=0, mem_err=0, all perf counters 0.
- While rst is high, outputs are forced to all enables 1 and all clears 1, so every pipeline register clears.

## Timing
- All stall/flush outputs are combinational from inputs and md_cnt, so they take effect at the edge ending the current cycle.
- E_md_start in cycle t (no freeze): md_busy is high in cycles t+1 … t+MD_LATENCY and low in t+MD_LATENCY+1.
- mem_err rises in the cycle after the MEM_TIMEOUT-th consecutive freeze cycle.
- mem_req with mem_ready in the same cycle: no freeze, state stays RUN.
- load_use and D_branch_taken together: stall wins, D_clr=0, E_clr=1.
- E_md_start while md_busy (illegal, precluded by md_stall): counter reloads to MD_LATENCY.
- rst during MEM_WAIT: state returns to RUN at that edge; mem_err clears.
- Counter saturation:
  - wait_cnt saturates at MEM_TIMEOUT.
  - Perf counters wrap modulo 2^32.

## Configuration
- `HAZARD_PERF_CNT_EN` defined, counters increment each non-reset cycle:
  - stall_cnt when md_stall or load_use is applied and freeze is low.
  - flush_cnt when D_clr is asserted by a flush.
  - memwait_cnt on every freeze cycle.
- `HAZARD_PERF_CNT_EN` undefined:
  - the three counter ports remain and are tied to 32'd0.
  - no counter flops are synthesised.

## Structure
- Package `hazard_pkg`:
  - state enum (RUN, MEM_WAIT)
  - default MD_LATENCY and MEM_TIMEOUT constants
  - MD_CNT_W=5
- Sub-module `md_busy_cnt`:
  - inputs clk, rst, start, hold_n
  - output busy
  - parameter LATENCY
  - contains the mult/div down-counter
- The FSM, wait counter, priority logic and perf counters are written inline in hazard_sched.

## Test plan
- **load_use only:** load_use=1 for one cycle → PC_en=0, D_en=0, E_clr=1 that cycle; next cycle all defaults; stall_cnt=1 (macro on).
- **Branch vs stall:** D_branch_taken=1 with load_use=1 → D_clr=0, E_clr=1; next cycle branch alone → D_clr=1, flush_cnt=1.
- **Memory wait:** M_mem_req=1, M_mem_ready=0 for 3 cycles, then ready=1 → 3 freeze cycles with W_clr=1 and load_use ignored; state returns to RUN; memwait_cnt=3.
- **Mult/div:** E_md_start at t; D_md_use=1 from t+1 → stall in t+1…t+5, release at t+6; start again during a 2-cycle freeze → no reload.
- **Timeout:** MEM_TIMEOUT=4, freeze held 6 cycles → mem_err=1 after the 4th cycle and stays 1 after freeze ends; rst → 0.
- **Reset mid-operation:** rst at md_cnt=3 in MEM_WAIT → next cycle md_busy=0, state RUN, all counters 0; during rst all enables and clears are 1.
